qch_device_responder: RTL and testbench
=======================================

# qch_device_responder

Generic device-side Q-channel responder that sits opposite the low-power controller and answers its quiescence requests. Synchronizes the controller's `qreqn`, runs a flush handshake with local device logic, then either accepts (`qacceptn` low) or denies (`qdenyn` low) the request. Replaces per-device ad-hoc Q-channel logic and adds deny support plus a bounded flush timeout.

## Interface
- `SYNC_STAGES`, default 2: flops on the `qreqn_i` synchronizer; must be ≥2.
- `FLUSH_TIMEOUT`, default 64: maximum cycles in FLUSH before the request is denied; 0 disables the timeout.
- `clk`  in  1  device clock.
- `reset`  in  1  synchronous, active-low reset.
- `qreqn_i`  in  1  quiescence request from the controller, asynchronous to `clk`.
- `qacceptn_o`  out  1  accept, active low; registered.
- `qdenyn_o`  out  1  deny, active low; registered.
- `qactive_o`  out  1  device activity indication; registered.
- `if_wakeup_i`  in  1  local wakeup event.
- `busy_i`  in  1  local transaction in progress.
- `flush_o`  out  1  request to local logic to drain or flush; registered.
- `flush_done_i`  in  1  local logic is drained; level sampled in FLUSH.
- `dev_stopped_o`  out  1  high while in STOPPED.
- `state_o`  out  2  current FSM state, for debug.

## Operation
- `qreqn_s` is `qreqn_i` after `SYNC_STAGES` flops. The synchronizer flops reset to 1.
- States: RUN, FLUSH, STOPPED, DENIED.
- **RUN**: `qacceptn_o` = 1 and `qdenyn_o` = 1.
  - If `qreqn_s` = 0 and (`busy_i` | `if_wakeup_i`), go to DENIED.
  - If `qreqn_s` = 0 and the device is idle, go to FLUSH and clear the timeout counter.
- **FLUSH**: `flush_o` = 1 and the timeout counter increments each cycle.
  - If `flush_done_i` = 1, go to STOPPED.
  - Otherwise, if `FLUSH_TIMEOUT` ≠ 0 and the counter equals `FLUSH_TIMEOUT` − 1, go to DENIED.
  - When done and timeout occur in the same cycle, done wins.
  - `qreqn_s` rising during FLUSH is a protocol violation and is ignored.
- **STOPPED**: `qacceptn_o` = 0 and `dev_stopped_o` = 1. When `qreqn_s` = 1, go to RUN and raise `qacceptn_o`.
- **DENIED**: `qdenyn_o` = 0. When `qreqn_s` = 1, go to RUN and raise `qdenyn_o`.
- `qactive_o` is registered from `if_wakeup_i` | `busy_i` | (next state == DENIED). A wakeup in STOPPED raises `qactive_o` so the controller exits; the FSM itself stays in STOPPED until `qreqn_s` = 1.
- `qacceptn_o` and `qdenyn_o` are never low together.
- Counter width is `$clog2(FLUSH_TIMEOUT+1)`. The counter saturates and never wraps.

## Timing
- Reset (`reset` = 0 at a `clk` edge) forces:
  - state RUN;
  - `qacceptn_o` = 1, `qdenyn_o` = 1, `qactive_o` = 0, `flush_o` = 0, `dev_stopped_o` = 0, `state_o` = RUN;
  - counter 0, synchronizer all 1s.
- Reset mid-FLUSH or in STOPPED/DENIED drops directly to RUN with the values above. The controller must restart its handshake.
- `qreqn_i` edge to `qreqn_s` edge: `SYNC_STAGES` cycles.
- `qreqn_s` falls at edge N:
  - deny path: `qdenyn_o` = 0 after edge N+1;
  - flush path: `flush_o` = 1 after edge N+1.
- `flush_done_i` sampled high at edge M gives `flush_o` = 0 and `qacceptn_o` = 0 after edge M.
- Timeout: `flush_o` = 1 for exactly `FLUSH_TIMEOUT` cycles, then `qdenyn_o` = 0 on the next cycle.
- Exit: `qreqn_s` = 1 at edge K gives `qacceptn_o` or `qdenyn_o` = 1 after edge K. The FSM is in RUN and may accept a new request at K+1.

## Structure
- Package `qch_pkg`:
  - `qch_state_e` enum (2 bits): RUN = 0, FLUSH = 1, STOPPED = 2, DENIED = 3.
  - Constant `QCH_SYNC_MIN` = 2.
  - Shared with the controller for debug decode.
- Sub-module `qch_sync`: parameterized N-flop single-bit synchronizer with synchronous active-low reset to a parameterized value (1 here).
- The FSM, timeout counter and output registers live in `qch_device_responder`.

## Test plan
- Idle accept: `busy_i` = 0, drop `qreqn_i`; `flush_done_i` = 1 three cycles after `flush_o` rises. Expect `flush_o` high for 3 cycles, then `qacceptn_o` = 0 and `dev_stopped_o` = 1. Raise `qreqn_i`: `qacceptn_o` = 1 after `SYNC_STAGES` + 1 edges.
- Busy deny: `busy_i` = 1, drop `qreqn_i`. Expect `qdenyn_o` = 0 with `flush_o` never asserted. Raise `qreqn_i`: `qdenyn_o` returns to 1 and the state is RUN.
- Flush timeout: `FLUSH_TIMEOUT` = 8 and `flush_done_i` held 0. Expect `flush_o` high for exactly 8 cycles, then `qdenyn_o` = 0 and `qactive_o` = 1. Variant: `flush_done_i` asserted on the 8th FLUSH cycle must accept (done beats timeout).
- Wakeup while stopped: in STOPPED, pulse `if_wakeup_i` for 1 cycle. Expect `qactive_o` = 1 for 1 cycle, FSM remains in STOPPED, `qacceptn_o` stays 0 until `qreqn_i` rises.
- Reset mid-flush: `reset` = 0 during FLUSH. Expect all outputs at their reset values on the next edge, and a fresh request completes normally afterwards.
- Throughout all scenarios, assert `qacceptn_o` and `qdenyn_o` are never both 0.

Source files
------------

// File: rtl/qch_pkg.sv
// Q-channel shared types and constants, also used by the controller for debug decode.
package qch_pkg;

  typedef enum logic [1:0] {
    QCH_RUN     = 2'd0,
    QCH_FLUSH   = 2'd1,
    QCH_STOPPED = 2'd2,
    QCH_DENIED  = 2'd3
  } qch_state_e;

  localparam int unsigned QCH_SYNC_MIN = 2;

endpackage

// File: rtl/qch_sync.sv
// N-flop single-bit synchronizer with synchronous active-low reset to a chosen value.
module qch_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/qch_device_responder.sv
// Device-side Q-channel responder: syncs qreqn, flushes local logic, then accepts or denies.
module qch_device_responder
  import qch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       qreqn_i,
  output logic       qacceptn_o,
  output logic       qdenyn_o,
  output logic       qactive_o,
  input  logic       if_wakeup_i,
  input  logic       busy_i,
  output logic       flush_o,
  input  logic       flush_done_i,
  output logic       dev_stopped_o,
  output logic [1:0] state_o
);

  localparam int unsigned CNT_W = (FLUSH_TIMEOUT == 0) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
  localparam bit          TIMEOUT_EN = (FLUSH_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(FLUSH_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (SYNC_STAGES < QCH_SYNC_MIN) begin : g_sync_too_short
    $error("qch_device_responder: SYNC_STAGES must be at least 2");
  end

  logic             qreqn_s;
  qch_state_e       state_q;
  qch_state_e       state_nxt;
  logic [CNT_W-1:0] cnt_q;

  qch_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (qreqn_i),
    .q     (qreqn_s)
  );

  // Next-state decode; done beats timeout, qreqn rising in FLUSH is ignored.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      QCH_RUN: begin
        if (!qreqn_s) begin
          state_nxt = (busy_i || if_wakeup_i) ? QCH_DENIED : QCH_FLUSH;
        end
      end
      QCH_FLUSH: begin
        if (flush_done_i) begin
          state_nxt = QCH_STOPPED;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_nxt = QCH_DENIED;
        end
      end
      QCH_STOPPED: begin
        if (qreqn_s) state_nxt = QCH_RUN;
      end
      QCH_DENIED: begin
        if (qreqn_s) state_nxt = QCH_RUN;
      end
      default: state_nxt = QCH_RUN;
    endcase
  end

  // State, saturating flush timer and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= QCH_RUN;
      cnt_q         <= '0;
      qacceptn_o    <= 1'b1;
      qdenyn_o      <= 1'b1;
      qactive_o     <= 1'b0;
      flush_o       <= 1'b0;
      dev_stopped_o <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == QCH_RUN) begin
        cnt_q <= '0;
      end else if ((state_q == QCH_FLUSH) && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      qacceptn_o    <= (state_nxt != QCH_STOPPED);
      qdenyn_o      <= (state_nxt != QCH_DENIED);
      qactive_o     <= if_wakeup_i || busy_i || (state_nxt == QCH_DENIED);
      flush_o       <= (state_nxt == QCH_FLUSH);
      dev_stopped_o <= (state_nxt == QCH_STOPPED);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_qch_device_responder.sv
// Scoreboard bench: each expected output segment (value + run length) is queued by the stimulus
// and checked by a monitor whenever the DUT output vector changes.
module tb_qch_device_responder;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned FLUSH_TIMEOUT = 8;

  // Output vector: {qacceptn, qdenyn, qactive, flush, dev_stopped, state[1:0]}
  localparam logic [6:0] V_RUN  = 7'b1100000;
  localparam logic [6:0] V_RUNA = 7'b1110000;
  localparam logic [6:0] V_FL   = 7'b1101001;
  localparam logic [6:0] V_ST   = 7'b0100110;
  localparam logic [6:0] V_STA  = 7'b0110110;
  localparam logic [6:0] V_DN   = 7'b1010011;

  typedef struct packed {
    logic [6:0]  v;
    int unsigned dur;   // 0 = length not checked
  } seg_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       qreqn_i;
  logic       qacceptn_o;
  logic       qdenyn_o;
  logic       qactive_o;
  logic       if_wakeup_i;
  logic       busy_i;
  logic       flush_o;
  logic       flush_done_i;
  logic       dev_stopped_o;
  logic [1:0] state_o;

  seg_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  bit   stop_mon = 1'b0;
  bit   mon_done = 1'b0;

  always #5 clk = ~clk;

  qch_device_responder #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .qreqn_i       (qreqn_i),
    .qacceptn_o    (qacceptn_o),
    .qdenyn_o      (qdenyn_o),
    .qactive_o     (qactive_o),
    .if_wakeup_i   (if_wakeup_i),
    .busy_i        (busy_i),
    .flush_o       (flush_o),
    .flush_done_i  (flush_done_i),
    .dev_stopped_o (dev_stopped_o),
    .state_o       (state_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] v, input int unsigned dur);
    seg_t s;
    s.v   = v;
    s.dur = dur;
    exp_q.push_back(s);
  endtask

  // Idle request: flush for three cycles, stop, then release.
  task automatic idle_accept();
    push(V_FL, 3);
    push(V_ST, 6);
    push(V_RUN, 0);
    qreqn_i = 1'b0;
    tick(5);
    flush_done_i = 1'b1;
    tick(1);
    flush_done_i = 1'b0;
    tick(3);
    qreqn_i = 1'b1;
    tick(6);
  endtask

  // Monitor: close a segment whenever the output vector changes and compare it.
  task automatic close_seg(input logic [6:0] v, input int unsigned run);
    seg_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL seg_unexpected: got vec=%b len=%0d, required no further output change", v, run);
    end else begin
      e = exp_q.pop_front();
      if (v !== e.v) begin
        errors++;
        $display("FAIL seg_value: got vec=%b, required %b", v, e.v);
      end else if ((e.dur != 0) && (run != e.dur)) begin
        errors++;
        $display("FAIL seg_length: vec=%b held %0d cycles, required %0d", v, run, e.dur);
      end
    end
  endtask

  initial begin
    logic [6:0]  prev;
    logic [6:0]  cur;
    int unsigned run;
    @(posedge clk);
    @(negedge clk);
    prev = {qacceptn_o, qdenyn_o, qactive_o, flush_o, dev_stopped_o, state_o};
    run  = 1;
    forever begin
      @(negedge clk);
      cur = {qacceptn_o, qdenyn_o, qactive_o, flush_o, dev_stopped_o, state_o};
      checks++;
      if ((qacceptn_o === 1'b0) && (qdenyn_o === 1'b0)) begin
        errors++;
        $display("FAIL accept_deny_excl: qacceptn=%b qdenyn=%b, required not both 0", qacceptn_o, qdenyn_o);
      end
      if ((cur !== prev) || stop_mon) begin
        close_seg(prev, run);
        prev = cur;
        run  = 1;
      end else begin
        run++;
      end
      if (stop_mon) break;
    end
    mon_done = 1'b1;
  end

  initial begin
    reset        = 1'b0;
    qreqn_i      = 1'b1;
    if_wakeup_i  = 1'b0;
    busy_i       = 1'b0;
    flush_done_i = 1'b0;
    push(V_RUN, 0);
    tick(3);
    reset = 1'b1;
    tick(2);

    // Idle accept
    idle_accept();

    // Busy deny: qactive from busy first, then deny, no flush
    push(V_RUNA, 2);
    push(V_DN, 4);
    push(V_RUN, 0);
    busy_i  = 1'b1;
    qreqn_i = 1'b0;
    tick(4);
    busy_i  = 1'b0;
    qreqn_i = 1'b1;
    tick(6);

    // Flush timeout: exactly 8 flush cycles, then deny with qactive
    push(V_FL, 8);
    push(V_DN, 4);
    push(V_RUN, 0);
    qreqn_i = 1'b0;
    tick(12);
    qreqn_i = 1'b1;
    tick(6);

    // Done on the 8th flush cycle wins; then a wakeup pulse while stopped
    push(V_FL, 8);
    push(V_ST, 3);
    push(V_STA, 1);
    push(V_ST, 5);
    push(V_RUN, 0);
    qreqn_i = 1'b0;
    tick(10);
    flush_done_i = 1'b1;
    tick(1);
    flush_done_i = 1'b0;
    tick(2);
    if_wakeup_i = 1'b1;
    tick(1);
    if_wakeup_i = 1'b0;
    tick(3);
    qreqn_i = 1'b1;
    tick(6);

    // Reset mid-flush, then a fresh request completes
    push(V_FL, 3);
    push(V_RUN, 0);
    qreqn_i = 1'b0;
    tick(5);
    reset   = 1'b0;
    qreqn_i = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(3);
    idle_accept();

    tick(2);
    stop_mon = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (!mon_done) begin
      errors++;
      $display("FAIL monitor_stop: monitor still running, required stopped");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL seg_missing: %0d expected segments never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
